// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared constants and types for the vector register file
package vec_pkg;

    // Register file geometry
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int LANES    = 4;
    localparam int LANE_W   = 32;
    localparam int VEC_W    = LANES * LANE_W;

    // Register index
    typedef logic [ADDR_W-1:0] vreg_addr_t;

    // One 32-bit lane
    typedef logic [LANE_W-1:0] vlane_t;

    // One vector register, lane 0 at the least significant bits
    typedef logic [LANES-1:0][LANE_W-1:0] vreg_t;

endpackage

// File: rtl/vrf_read_mux.sv
// rtl/vrf_read_mux.sv - combinational NUM_REGS:1 vector read selector
module vrf_read_mux
    import vec_pkg::*;
(
    input  vreg_t      regs [NUM_REGS],
    input  vreg_addr_t ra,
    output vreg_t      rd
);

    // Zero-latency select of the addressed register; no write bypass here
    always_comb begin
        rd = regs[ra];
    end

endmodule

// File: rtl/vector_register_file.sv
// rtl/vector_register_file.sv - 16 x 128-bit vector register file, 2 read / 1 write
module vector_register_file
    import vec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [VEC_W-1:0]  wd3,
    output logic [VEC_W-1:0]  rd1,
    output logic [VEC_W-1:0]  rd2
);

    vreg_t               regs [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;
    vreg_t               wdata;
    vreg_t               rdata1;
    vreg_t               rdata2;

    assign wdata = wd3;

    // One-hot write decode; compared per index so an unknown wa3 cannot
    // select a register while we3 is low
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = we3 && (wa3 == ADDR_W'(i));
        end
    end

    // Storage: async clear has priority, otherwise full-width write of the
    // decoded register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    vrf_read_mux u_read_mux1 (
        .regs (regs),
        .ra   (ra1),
        .rd   (rdata1)
    );

    vrf_read_mux u_read_mux2 (
        .regs (regs),
        .ra   (ra2),
        .rd   (rdata2)
    );

    assign rd1 = rdata1;
    assign rd2 = rdata2;

endmodule

// File: tb/tb_vector_register_file.sv
// tb/tb_vector_register_file.sv - randomized self-checking bench for vector_register_file
module tb_vector_register_file;

    logic         clk;
    logic         rst;
    logic         we3;
    logic [3:0]   ra1;
    logic [3:0]   ra2;
    logic [3:0]   wa3;
    logic [127:0] wd3;
    logic [127:0] rd1;
    logic [127:0] rd2;

    logic [127:0] model [16];
    int passed;
    int total;

    vector_register_file dut (
        .clk (clk),
        .rst (rst),
        .we3 (we3),
        .ra1 (ra1),
        .ra2 (ra2),
        .wa3 (wa3),
        .wd3 (wd3),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; the reference model commits the write the
    // inputs requested at that edge, then we step 1ns past it
    task automatic step();
        logic         w;
        logic [3:0]   a;
        logic [127:0] d;
        w = we3 && !rst;
        a = wa3;
        d = wd3;
        @(posedge clk);
        if (w) model[a] = d;
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_both(input string tag);
        #1;
        check({tag, "_rd1"}, rd1, model[ra1]);
        check({tag, "_rd2"}, rd2, model[ra2]);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            ra1 = 4'(i);
            ra2 = 4'(15 - i);
            #1;
            check({tag, "_rd1"}, rd1, 128'd0);
            check({tag, "_rd2"}, rd2, 128'd0);
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        rst = 1'b1;
        we3 = 1'b0;
        ra1 = '0;
        ra2 = '0;
        wa3 = '0;
        wd3 = '0;

        // Reset state on every address of both ports
        step();
        check_all_zero("reset");

        // Release reset, no writes: still zero
        rst = 1'b0;
        step();
        step();
        check_all_zero("post_reset");

        // Basic write, lane ordering
        we3 = 1'b1;
        wa3 = 4'd0;
        wd3 = {32'd4, 32'd3, 32'd2, 32'd1};
        step();
        we3 = 1'b0;
        ra1 = 4'd0;
        #1;
        check("lane0", {96'd0, rd1[31:0]},   128'd1);
        check("lane1", {96'd0, rd1[63:32]},  128'd2);
        check("lane2", {96'd0, rd1[95:64]},  128'd3);
        check("lane3", {96'd0, rd1[127:96]}, 128'd4);

        // Dual-port independence and same-cycle swap
        we3 = 1'b1;
        wa3 = 4'd5;
        wd3 = {32{4'hA}};
        step();
        wa3 = 4'd10;
        wd3 = {32{4'h5}};
        step();
        we3 = 1'b0;
        ra1 = 4'd5;
        ra2 = 4'd10;
        #1;
        check("dual_rd1", rd1, {32{4'hA}});
        check("dual_rd2", rd2, {32{4'h5}});
        ra1 = 4'd10;
        ra2 = 4'd5;
        #1;
        check("swap_rd1", rd1, {32{4'h5}});
        check("swap_rd2", rd2, {32{4'hA}});

        // Same address on both ports
        ra1 = 4'd5;
        ra2 = 4'd5;
        #1;
        check("same_addr", rd1, rd2);
        check("same_addr_val", rd2, {32{4'hA}});

        // Write enable low leaves the register unchanged
        we3 = 1'b1;
        wa3 = 4'd3;
        wd3 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        step();
        we3 = 1'b0;
        wd3 = {128{1'b1}};
        step();
        ra1 = 4'd3;
        #1;
        check("we_low", rd1, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);

        // Same-address read/write: old value before the edge, new after
        we3 = 1'b1;
        wa3 = 4'd7;
        wd3 = 128'd1;
        step();
        wd3 = 128'd2;
        ra1 = 4'd7;
        #1;
        check("rw_before", rd1, 128'd1);
        step();
        we3 = 1'b0;
        #1;
        check("rw_after", rd1, 128'd2);

        // Randomized traffic against the array model
        for (int n = 0; n < 300; n++) begin
            we3 = ($urandom_range(0, 3) != 0);
            wa3 = 4'($urandom_range(0, 15));
            wd3 = rnd128();
            ra1 = 4'($urandom_range(0, 15));
            ra2 = ($urandom_range(0, 7) == 0) ? wa3 : 4'($urandom_range(0, 15));
            check_both("rand_pre");
            step();
            check_both("rand_post");
        end

        // Fill every register with a distinct value
        we3 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wa3 = 4'(i);
            wd3 = {4{8'(i + 1), 24'h5a5a00 + 24'(i)}};
            step();
        end
        we3 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ra1 = 4'(i);
            ra2 = 4'(15 - i);
            check_both("fill");
        end

        // Async reset between edges: outputs drop before the next edge
        ra1 = 4'd9;
        ra2 = 4'd14;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rd1", rd1, 128'd0);
        check("async_rd2", rd2, 128'd0);
        for (int i = 0; i < 16; i++) model[i] = '0;

        // Write attempted while reset is held is ignored
        we3 = 1'b1;
        wa3 = 4'd9;
        wd3 = rnd128();
        step();
        we3 = 1'b0;
        check_all_zero("rst_write");
        rst = 1'b0;
        step();
        ra1 = 4'd9;
        ra2 = 4'd0;
        check_both("rst_release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
